// File: rtl/qtree_cfg_loader.sv
// qtree_cfg_loader: bulk table-update initiator for the quadtree lookup engine.
// Turns stream-write and constant-fill commands into a control write sequence
// (one word per strobe), drains the lookup pipeline, then pulses done_o.
// Optional feature macro: QTREE_CFG_LOADER_LOOKUP_HOLD_EN adds lookup_hold_o,
// a registered stall request covering the whole table update.
module qtree_cfg_loader #(
  parameter int MM_ADDR_WIDTH = 16,
  parameter int MM_DATA_WIDTH = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int DRAIN_CYCLES  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [MM_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [MM_DATA_WIDTH-1:0] cmd_fill_i,
  input  logic                     wr_valid_i,
  input  logic [MM_DATA_WIDTH-1:0] wr_data_i,
  output logic                     wr_ready_o,
  output logic [MM_ADDR_WIDTH-1:0] mm_ctrl_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_ctrl_data_o,
  output logic                     mm_ctrl_write_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
  ,
  output logic                     lookup_hold_o
`endif
);

  localparam int SUM_WIDTH = ((MM_ADDR_WIDTH > LEN_WIDTH) ? MM_ADDR_WIDTH : LEN_WIDTH) + 1;
  localparam int CNT_WIDTH = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]               state_q;
  logic [2:0]               state_d;
  logic [MM_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]     rem_q;
  logic [MM_DATA_WIDTH-1:0] fill_q;
  logic                     err_flag_q;
  logic [CNT_WIDTH-1:0]     drain_q;

  logic                     cmd_accept;
  logic                     beat_accept;
  logic [SUM_WIDTH-1:0]     span_end;
  logic [MM_ADDR_WIDTH-1:0] last_addr;
  logic                     range_over;
  logic                     msb_cross;
  logic                     cmd_err;

  // The ready outputs are registered copies of the state, so they double as
  // the state qualifiers for the handshakes.
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign beat_accept = wr_valid_i && wr_ready_o;

  // Range check of the incoming command: overrun of the address space, or
  // first and last word on different sides of the level/match split.
  always_comb begin
    span_end   = SUM_WIDTH'(cmd_addr_i) + SUM_WIDTH'(cmd_len_i);
    last_addr  = cmd_addr_i + MM_ADDR_WIDTH'(cmd_len_i) - MM_ADDR_WIDTH'(1);
    range_over = span_end > (SUM_WIDTH'(1) << MM_ADDR_WIDTH);
    msb_cross  = (cmd_len_i != '0) &&
                 (cmd_addr_i[MM_ADDR_WIDTH-1] != last_addr[MM_ADDR_WIDTH-1]);
    cmd_err    = cmd_op_i[1] || range_over || msb_cross;
  end

  // Next-state logic of the command sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          if (cmd_len_i == '0 || cmd_op_i[1]) begin
            state_d = ST_DRAIN;
          end else if (cmd_op_i[0]) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (beat_accept && rem_q == LEN_WIDTH'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL: begin
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, command context, write port and status registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      fill_q          <= '0;
      err_flag_q      <= 1'b0;
      drain_q         <= '0;
      cmd_ready_o     <= 1'b0;
      wr_ready_o      <= 1'b0;
      mm_ctrl_addr_o  <= '0;
      mm_ctrl_data_o  <= '0;
      mm_ctrl_write_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state_q         <= state_d;
      mm_ctrl_write_o <= 1'b0;
      // Ready returns the cycle after done_o, the same cycle busy_o drops.
      cmd_ready_o     <= (state_d == ST_IDLE) && (state_q != ST_DONE);
      wr_ready_o      <= (state_d == ST_STREAM);
      busy_o          <= (state_d != ST_IDLE) || (state_q == ST_DONE);
      done_o          <= (state_q == ST_DONE);
      err_o           <= (state_q == ST_DONE) && err_flag_q;

      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            addr_q     <= cmd_addr_i;
            rem_q      <= cmd_len_i;
            fill_q     <= cmd_fill_i;
            err_flag_q <= cmd_err;
          end
        end
        ST_STREAM: begin
          if (beat_accept) begin
            mm_ctrl_addr_o  <= addr_q;
            mm_ctrl_data_o  <= wr_data_i;
            mm_ctrl_write_o <= 1'b1;
            addr_q          <= addr_q + MM_ADDR_WIDTH'(1);
            rem_q           <= rem_q - LEN_WIDTH'(1);
          end
        end
        ST_FILL: begin
          mm_ctrl_addr_o  <= addr_q;
          mm_ctrl_data_o  <= fill_q;
          mm_ctrl_write_o <= 1'b1;
          addr_q          <= addr_q + MM_ADDR_WIDTH'(1);
          rem_q           <= rem_q - LEN_WIDTH'(1);
        end
        default: ;
      endcase

      if (state_d == ST_DRAIN && state_q != ST_DRAIN) begin
        drain_q <= CNT_WIDTH'(DRAIN_CYCLES - 1);
      end else if (state_q == ST_DRAIN && drain_q != '0) begin
        drain_q <= drain_q - CNT_WIDTH'(1);
      end
    end
  end

`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
  // Lookup stall request: rises the cycle after accept, falls after done_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_hold_o <= 1'b0;
    end else begin
      lookup_hold_o <= (state_d != ST_IDLE) || (state_q == ST_DONE);
    end
  end
`endif

endmodule

// File: tb/tb_qtree_cfg_loader.sv
// Self-checking bench for qtree_cfg_loader: randomized fill/stream commands
// compared against an arithmetic reference model of the write sequence.
module tb_qtree_cfg_loader;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = '0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [DW-1:0] cmd_fill_i = '0;
  logic          wr_valid_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_ready_o;
  logic [AW-1:0] mm_ctrl_addr_o;
  logic [DW-1:0] mm_ctrl_data_o;
  logic          mm_ctrl_write_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
  logic          lookup_hold_o;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qtree_cfg_loader #(
    .MM_ADDR_WIDTH(AW),
    .MM_DATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i),
    .cmd_fill_i(cmd_fill_i),
    .wr_valid_i(wr_valid_i),
    .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o),
    .mm_ctrl_addr_o(mm_ctrl_addr_o),
    .mm_ctrl_data_o(mm_ctrl_data_o),
    .mm_ctrl_write_o(mm_ctrl_write_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
    ,
    .lookup_hold_o(lookup_hold_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Observed behaviour of the last command.
  logic [AW-1:0] cap_addr[$];
  logic [DW-1:0] cap_data[$];
  int            cap_cyc[$];
  int            beat_cyc[$];
  logic [DW-1:0] sdata[$];
  int            gap_plan[$];
  logic [DW-1:0] data_plan[$];
  int            acc_cyc, done_cnt, done_cyc, proto_bad;
  logic          done_err, busy_after, timed_out;
  int            hold_rise, hold_fall;
  logic          snap_write, snap_busy, snap_wrready, snap_cmdready, snap_done;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_data;

  // Expected behaviour from the reference model.
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            exp_cyc[$];
  logic          exp_err;
  int            exp_done;

  // Reference model: word i goes to (addr+i) mod 2^16; fill words appear from
  // accept+2 on consecutive cycles, stream words one cycle after their beat;
  // done_o follows the last write by D+1 cycles (accept+D+2 with no writes).
  task automatic build_expect(input int unsigned op, input int unsigned addr,
                              input int unsigned len, input logic [DW-1:0] fill);
    int unsigned first_msb, last_msb;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    first_msb = (addr >> 15) & 1;
    last_msb  = (len > 0) ? (((addr + len - 1) % 65536) >> 15) & 1 : first_msb;
    exp_err   = (op > 1) || (addr + len > 65536) || (first_msb != last_msb);
    if (op <= 1) begin
      for (int unsigned i = 0; i < len; i++) begin
        exp_addr.push_back(16'((addr + i) % 65536));
        exp_data.push_back((op == 1) ? fill : ((i < sdata.size()) ? sdata[i] : '0));
        if (op == 1) exp_cyc.push_back(acc_cyc + 2 + int'(i));
        else exp_cyc.push_back((i < beat_cyc.size()) ? beat_cyc[i] + 1 : -1);
      end
    end
    exp_done = (exp_cyc.size() > 0) ? exp_cyc[exp_cyc.size()-1] + D + 1 : acc_cyc + D + 2;
  endtask

  function automatic int pick_gap(input int i, input int max_gap);
    if (i < gap_plan.size()) return gap_plan[i];
    return int'($urandom_range(0, max_gap));
  endfunction

  // Drives one command (and its stream beats) and records everything observed
  // at falling edges until three cycles after done_o, or until reset is
  // asserted after abort_beats stream beats (abort_beats < 0: never).
  task automatic run_cmd(input int unsigned op, input int unsigned addr, input int unsigned len,
                         input logic [DW-1:0] fill, input int max_gap, input int abort_beats);
    int  idx, gap, limit;
    bit  accepted, finished;
    logic hold_prev;
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); beat_cyc.delete(); sdata.delete();
    for (int unsigned i = 0; i < len; i++)
      sdata.push_back((i < data_plan.size()) ? data_plan[i] : $urandom);
    acc_cyc = -1; done_cnt = 0; done_cyc = -1; done_err = 1'b0; busy_after = 1'b1;
    proto_bad = 0; timed_out = 1'b0; hold_rise = -1; hold_fall = -1; hold_prev = 1'b0;
    accepted = 0; finished = 0; idx = 0; gap = pick_gap(0, max_gap);
    limit = 40 + int'(len) * (max_gap + 2) + D;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (mm_ctrl_write_o) begin
        cap_addr.push_back(mm_ctrl_addr_o); cap_data.push_back(mm_ctrl_data_o); cap_cyc.push_back(cyc);
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; done_err = err_o; end
      if (accepted && done_cnt == 0 && cyc > acc_cyc && (cmd_ready_o || !busy_o)) proto_bad++;
      if (wr_ready_o && (op != 0 || idx >= int'(len))) proto_bad++;
`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
      if (lookup_hold_o && !hold_prev) hold_rise = cyc;
      if (!lookup_hold_o && hold_prev) hold_fall = cyc;
      hold_prev = lookup_hold_o;
`endif
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy_o;
      if (done_cnt > 0 && cyc >= done_cyc + 3) begin finished = 1; break; end
      if (abort_beats >= 0 && idx == abort_beats) begin
        rst_i = 1'b0;
        #1;
        snap_write = mm_ctrl_write_o; snap_busy = busy_o; snap_wrready = wr_ready_o;
        snap_cmdready = cmd_ready_o; snap_done = done_o;
        snap_addr = mm_ctrl_addr_o; snap_data = mm_ctrl_data_o;
        finished = 1;
        break;
      end
      if (!accepted) begin
        cmd_valid_i = 1'b1; cmd_op_i = op[1:0]; cmd_addr_i = addr[AW-1:0];
        cmd_len_i = len[LW-1:0]; cmd_fill_i = fill;
        if (cmd_ready_o) begin accepted = 1; acc_cyc = cyc; end
      end else begin
        cmd_valid_i = 1'b0;
      end
      if (op == 0 && idx < int'(len)) begin
        if (gap > 0) begin
          wr_valid_i = 1'b0; gap--;
        end else begin
          wr_valid_i = 1'b1; wr_data_i = sdata[idx];
          if (wr_ready_o) begin
            beat_cyc.push_back(cyc); idx++; gap = pick_gap(idx, max_gap);
          end
        end
      end else begin
        wr_valid_i = 1'b0;
      end
    end
    cmd_valid_i = 1'b0; wr_valid_i = 1'b0;
    if (!finished) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready_o, wr_ready_o, mm_ctrl_write_o, busy_o, done_o, err_o} !== 6'b0 ||
        mm_ctrl_addr_o !== '0 || mm_ctrl_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b wrdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               cmd_ready_o, wr_ready_o, mm_ctrl_write_o, busy_o, done_o, err_o, mm_ctrl_addr_o, mm_ctrl_data_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || wr_ready_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b busy=%b wrdy=%b done=%b required 1/0/0/0",
               cmd_ready_o, busy_o, wr_ready_o, done_o);
    end
  endtask

  task automatic test_fill();
    int unsigned addr, len;
    logic [DW-1:0] fill;
    for (int t = 0; t < 6; t++) begin
      addr = (t == 0) ? 32'h10 : $urandom_range(0, 32'h7FF0);
      len  = (t == 0) ? 4 : $urandom_range(1, 12);
      fill = (t == 0) ? 32'hDEADBEEF : $urandom;
      run_cmd(1, addr, len, fill, 0, -1);
      build_expect(1, addr, len, fill);
      checks++;
      if (timed_out) begin failures++; $display("FAIL fill_timeout: got no done_o required done_o (t=%0d)", t); end
      checks++;
      if (cap_addr.size() != exp_addr.size()) begin
        failures++; $display("FAIL fill_count: got %0d writes required %0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_cyc[i] !== exp_cyc[i]) begin
          failures++;
          $display("FAIL fill_write%0d: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   i, cap_addr[i], cap_data[i], cap_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
        end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done) begin
        failures++; $display("FAIL fill_done: got count=%0d cyc=%0d required count=1 cyc=%0d", done_cnt, done_cyc, exp_done);
      end
      checks++;
      if (done_err !== exp_err) begin failures++; $display("FAIL fill_err: got %b required %b", done_err, exp_err); end
      checks++;
      if (proto_bad !== 0 || busy_after !== 1'b0) begin
        failures++; $display("FAIL fill_handshake: got violations=%0d busy_after=%b required 0/0", proto_bad, busy_after);
      end
    end
  endtask

  task automatic test_stream();
    int unsigned addr, len;
    for (int t = 0; t < 6; t++) begin
      gap_plan.delete(); data_plan.delete();
      if (t == 0) begin
        addr = 32'h8000; len = 3;
        gap_plan = '{0, 0, 2};
        data_plan = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      end else begin
        addr = $urandom_range(32'h8000, 32'hFFE0); len = $urandom_range(1, 10);
      end
      run_cmd(0, addr, len, '0, 3, -1);
      build_expect(0, addr, len, '0);
      gap_plan.delete(); data_plan.delete();
      checks++;
      if (timed_out) begin failures++; $display("FAIL stream_timeout: got no done_o required done_o (t=%0d)", t); end
      checks++;
      if (cap_addr.size() != exp_addr.size() || beat_cyc.size() != int'(len)) begin
        failures++; $display("FAIL stream_count: got %0d writes %0d beats required %0d", cap_addr.size(), beat_cyc.size(), len);
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_cyc[i] !== exp_cyc[i]) begin
          failures++;
          $display("FAIL stream_write%0d: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   i, cap_addr[i], cap_data[i], cap_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
        end
      end
      if (t == 0 && beat_cyc.size() == 3) begin
        checks++;
        if (beat_cyc[0] !== acc_cyc + 1 || beat_cyc[1] !== acc_cyc + 2 || beat_cyc[2] !== acc_cyc + 5) begin
          failures++;
          $display("FAIL stream_beats: got beat cycles %0d %0d %0d required %0d %0d %0d",
                   beat_cyc[0], beat_cyc[1], beat_cyc[2], acc_cyc + 1, acc_cyc + 2, acc_cyc + 5);
        end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done) begin
        failures++; $display("FAIL stream_done: got count=%0d cyc=%0d required count=1 cyc=%0d", done_cnt, done_cyc, exp_done);
      end
      checks++;
      if (done_err !== exp_err) begin failures++; $display("FAIL stream_err: got %b required %b", done_err, exp_err); end
      checks++;
      if (proto_bad !== 0 || busy_after !== 1'b0) begin
        failures++; $display("FAIL stream_handshake: got violations=%0d busy_after=%b required 0/0", proto_bad, busy_after);
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned addr, len;
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: begin addr = 32'hFFFE; len = 4; end
        1: begin addr = 32'h7FFE; len = 4; end
        2: begin addr = 32'h7FFC; len = 4; end
        3: begin addr = $urandom_range(32'hFFF0, 32'hFFFF); len = $urandom_range(1, 20); end
        default: begin addr = $urandom_range(32'h7FF0, 32'h7FFF); len = $urandom_range(1, 20); end
      endcase
      run_cmd(1, addr, len, 32'h5A5A_0000 + t, 0, -1);
      build_expect(1, addr, len, 32'h5A5A_0000 + t);
      checks++;
      if (timed_out) begin failures++; $display("FAIL wrap_timeout: got no done_o required done_o (t=%0d)", t); end
      checks++;
      if (cap_addr.size() != exp_addr.size()) begin
        failures++; $display("FAIL wrap_count: got %0d writes required %0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (cap_addr[i] !== exp_addr[i] || cap_cyc[i] !== exp_cyc[i]) begin
          failures++;
          $display("FAIL wrap_write%0d: got addr=%h cyc=%0d required addr=%h cyc=%0d",
                   i, cap_addr[i], cap_cyc[i], exp_addr[i], exp_cyc[i]);
        end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done || done_err !== exp_err) begin
        failures++;
        $display("FAIL wrap_done_err: got count=%0d cyc=%0d err=%b required count=1 cyc=%0d err=%b (addr=%h len=%0d)",
                 done_cnt, done_cyc, done_err, exp_done, exp_err, addr, len);
      end
    end
  endtask

  task automatic test_zero_reserved();
    int unsigned op, addr, len;
    for (int t = 0; t < 4; t++) begin
      op   = (t == 0) ? 1 : (t == 1) ? 0 : (t == 2) ? 3 : 2;
      len  = (t < 2) ? 0 : $urandom_range(1, 8);
      addr = (t == 1) ? 32'h8000 : $urandom_range(0, 32'hFFFF);
      run_cmd(op, addr, len, 32'h1234_5678, 0, -1);
      build_expect(op, addr, len, 32'h1234_5678);
      checks++;
      if (timed_out || cap_addr.size() != 0) begin
        failures++; $display("FAIL zero_writes: got %0d writes timeout=%b required 0 writes (op=%0d len=%0d)",
                             cap_addr.size(), timed_out, op, len);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done || done_err !== exp_err) begin
        failures++;
        $display("FAIL zero_done_err: got count=%0d cyc=%0d err=%b required count=1 cyc=%0d err=%b (op=%0d)",
                 done_cnt, done_cyc, done_err, exp_done, exp_err, op);
      end
      checks++;
      if (proto_bad !== 0 || busy_after !== 1'b0) begin
        failures++; $display("FAIL zero_handshake: got violations=%0d busy_after=%b required 0/0", proto_bad, busy_after);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int unsigned addr;
    int stray;
    addr = $urandom_range(0, 32'h7F00);
    run_cmd(0, addr, 5, '0, 0, 2);
    build_expect(0, addr, 5, '0);
    checks++;
    if (timed_out || {snap_write, snap_busy, snap_wrready, snap_cmdready, snap_done} !== 5'b0 ||
        snap_addr !== '0 || snap_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got wr=%b busy=%b wrdy=%b rdy=%b done=%b addr=%h data=%h required all 0",
               snap_write, snap_busy, snap_wrready, snap_cmdready, snap_done, snap_addr, snap_data);
    end
    checks++;
    if (cap_addr.size() != 2 || exp_addr.size() != 5 ||
        cap_addr[0] !== exp_addr[0] || cap_data[0] !== exp_data[0] ||
        cap_addr[1] !== exp_addr[1] || cap_data[1] !== exp_data[1]) begin
      failures++; $display("FAIL abort_partial: got %0d writes required first 2 words of the command", cap_addr.size());
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL abort_release: got rdy=%b busy=%b required 1/0", cmd_ready_o, busy_o);
    end
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o || mm_ctrl_write_o || busy_o) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL abort_no_done: got %0d active cycles required 0", stray); end
  endtask

  task automatic test_back_to_back();
    int unsigned a1, a2;
    int acc1, acc2, d1, d2, n, stage;
    a1 = $urandom_range(0, 32'h3000); a2 = $urandom_range(32'h4000, 32'h7000);
    cap_addr.delete(); cap_cyc.delete();
    acc1 = -1; acc2 = -1; d1 = -1; d2 = -1; stage = 0;
    for (n = 0; n < 80; n++) begin
      @(negedge clk);
      if (mm_ctrl_write_o) begin cap_addr.push_back(mm_ctrl_addr_o); cap_cyc.push_back(cyc); end
      if (done_o) begin if (d1 < 0) d1 = cyc; else d2 = cyc; end
      if (d2 >= 0) break;
      cmd_valid_i = (stage < 2); cmd_op_i = 2'd1;
      cmd_addr_i = (stage == 0) ? a1[AW-1:0] : a2[AW-1:0];
      cmd_len_i  = (stage == 0) ? 16'd2 : 16'd3;
      cmd_fill_i = 32'hB2B2_0000 + stage;
      if (stage < 2 && cmd_ready_o) begin
        if (stage == 0) acc1 = cyc; else acc2 = cyc;
        stage++;
      end
    end
    cmd_valid_i = 1'b0;
    checks++;
    if (acc1 < 0 || acc2 !== d1 + 1) begin
      failures++; $display("FAIL b2b_accept: got second accept cyc=%0d required %0d", acc2, d1 + 1);
    end
    checks++;
    if (cap_addr.size() != 5 || cap_addr[2] !== a2[AW-1:0] || cap_cyc[2] !== acc2 + 2 ||
        cap_cyc[0] !== acc1 + 2) begin
      failures++; $display("FAIL b2b_writes: got %0d writes required 5 with second command from cyc %0d", cap_addr.size(), acc2 + 2);
    end
    checks++;
    if (d2 < 0 || cap_cyc.size() != 5 || d2 !== cap_cyc[4] + D + 1) begin
      failures++; $display("FAIL b2b_done: got second done cyc=%0d required last write + %0d", d2, D + 1);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
  task automatic test_hold();
    run_cmd(1, 32'h0200, 3, 32'h0, 0, -1);
    checks++;
    if (timed_out || hold_rise !== acc_cyc + 1 || hold_fall !== done_cyc + 1) begin
      failures++;
      $display("FAIL hold_window: got rise=%0d fall=%0d required rise=%0d fall=%0d",
               hold_rise, hold_fall, acc_cyc + 1, done_cyc + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_wrap();
    test_zero_reserved();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef QTREE_CFG_LOADER_LOOKUP_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
